seq_divider: RTL

//  Parametrised multi-cycle restoring divider: the successor to the fixed 32-bit

---
 rtl/seq_divider.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Start/done handshake: a request is accepted on any rising edge where
// start==1 and the unit is not busy (IDLE or DONE state); busy is high for
// the whole RUN state; done is a one-cycle pulse in the DONE state, during
// which quotient/remainder/div_by_zero are already valid and a new start
// is accepted back-to-back.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's-complement mode
// selected per request by signed_mode). Without it signed_mode is ignored.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   rem_r;    // extra bit is the carry slot for the trial subtract
    logic [WIDTH-1:0] q_r;      // dividend shifts out, quotient bits shift in
    logic             dbz_r;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;
    logic a_neg;
    logic b_neg;
`endif

    // Bit WIDTH of rem_r is always zero between steps; only its low bits feed back.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_r[WIDTH];

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;
    assign accept    = start && ((state == IDLE) || (state == DONE));

    // One restoring step: shift in the next dividend bit, try subtracting the divisor.
    always_comb begin
        shifted = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_r};
        qbit    = ~trial[WIDTH];
    end

    // Operand magnitudes at capture, and sign fix-up of the finished result.
`ifdef SEQ_DIVIDER_SIGNED_EN
    always_comb begin
        a_neg = signed_mode && dividend[WIDTH-1];
        b_neg = signed_mode && divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
        q_fin = neg_q_r ? (~q_r + 1'b1) : q_r;
        r_fin = neg_r_r ? (~rem_r[WIDTH-1:0] + 1'b1) : rem_r[WIDTH-1:0];
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;

    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        q_fin = q_r;
        r_fin = rem_r[WIDTH-1:0];
    end
`endif

    // Control FSM, datapath registers and registered results.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt_r       <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            dbz_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (dbz_r || (cnt_r == LAST_CNT)) begin
                        state <= DONE;
                        if (dbz_r) begin
                            quotient    <= '1;
                            remainder   <= q_r;   // raw dividend kept for this case
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= q_fin;
                            remainder   <= r_fin;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        rem_r <= qbit ? trial : shifted;
                        q_r   <= {q_r[WIDTH-2:0], qbit};
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (accept) begin
                        state <= RUN;
                        cnt_r <= '0;
                        dvs_r <= b_mag;
                        rem_r <= '0;
                        dbz_r <= (divisor == '0);
                        q_r   <= (divisor == '0) ? dividend : a_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_r <= a_neg ^ b_neg;
                        neg_r_r <= a_neg;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
